// File: rtl/if_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package if_pkg;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned PC_STEP = 4;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;
   localparam int unsigned MEM_WORDS = 1024;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

   typedef enum logic {RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of instruction-memory, redirect and decode-handshake signals.
interface instr_fetch_unit_if;
   import if_pkg::*;

   logic               fetch_en;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic               fetch_fault;

   modport master (
      input  fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
      output imem_addr, out_valid, out_instr, out_pc, fetch_fault
   );

   modport slave (
      output fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc, fetch_fault
   );
endinterface

// File: rtl/fetch_buf2.sv
// Two-entry fetch FIFO; the head register doubles as the registered output
// and keeps its last contents when the buffer drains.
module fetch_buf2
   import if_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [1:0]   count,
   output logic         head_valid,
   output fetch_entry_t head
);
   fetch_entry_t head_q, head_d, tail_q, tail_d;
   logic         head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         head_vld_q <= 1'b0;
         tail_vld_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         head_vld_q <= head_vld_d;
         tail_vld_q <= tail_vld_d;
      end
   end

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      head_vld_d = head_vld_q;
      tail_vld_d = tail_vld_q;
      if (flush) begin
         head_vld_d = 1'b0;
         tail_vld_d = 1'b0;
      end else begin
         if (pop && head_vld_q) begin
            if (tail_vld_q) begin
               head_d     = tail_q;
               tail_vld_d = 1'b0;
            end else begin
               head_vld_d = 1'b0;
            end
         end
         // Occupancy after the pop decides which slot the new entry lands in.
         if (push) begin
            if (!head_vld_d) begin
               head_d     = din;
               head_vld_d = 1'b1;
            end else begin
               tail_d     = din;
               tail_vld_d = 1'b1;
            end
         end
      end
   end

   assign count      = {1'b0, head_vld_q} + {1'b0, tail_vld_q};
   assign head_valid = head_vld_q;
   assign head       = head_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, RUN/FAULT state machine and push/redirect
// arbitration in front of a two-entry output buffer.
module instr_fetch_unit #(
   parameter logic [if_pkg::ADDR_W-1:0] RESET_PC  = if_pkg::RESET_PC,
   parameter int unsigned               MEM_WORDS = if_pkg::MEM_WORDS
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);
   import if_pkg::*;

   localparam int unsigned MemLimit = MEM_WORDS * PC_STEP;

   logic [ADDR_W-1:0] pc_q, pc_d;
   fetch_state_t      state_q, state_d;
   logic              pop, push, flush, in_range, fetch_slot, head_valid;
   logic [1:0]        count;
   fetch_entry_t      head, din;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   // Widen before comparing: the limit may equal 2^ADDR_W.
   assign in_range   = {{(32-ADDR_W){1'b0}}, pc_q} < MemLimit;
   assign pop        = head_valid & bus.out_ready;
   assign fetch_slot = (state_q == RUN) & bus.fetch_en & ~bus.redirect_valid &
                       ((count != 2'd2) | pop);
   assign push       = fetch_slot & in_range;
   assign flush      = bus.redirect_valid;
   assign din        = '{instr: bus.imem_rdata, pc: pc_q};

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (bus.redirect_valid) begin
         pc_d    = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
         state_d = RUN;
      end else if (push) begin
         pc_d = pc_q + ADDR_W'(PC_STEP);
      end else if (fetch_slot) begin
         state_d = FAULT;
      end
   end

   fetch_buf2 u_buf (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .din        (din),
      .count      (count),
      .head_valid (head_valid),
      .head       (head)
   );

   assign bus.imem_addr   = pc_q;
   assign bus.out_valid   = head_valid;
   assign bus.out_instr   = head.instr;
   assign bus.out_pc      = head.pc;
   assign bus.fetch_fault = (state_q == FAULT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: queue-based fetch model for the main instance plus a
// second instance placed at the top of the address space for PC wrap.
module tb_instr_fetch_unit;
   import if_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus_a ();
   instr_fetch_unit_if bus_b ();

   instr_fetch_unit #(.RESET_PC(16'h0000), .MEM_WORDS(1024)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.master)
   );

   instr_fetch_unit #(.RESET_PC(16'hFFFC), .MEM_WORDS(16384)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.master)
   );

   logic [15:0] mem [16384];
   assign bus_a.imem_rdata = mem[bus_a.imem_addr[15:2]];
   assign bus_b.imem_rdata = mem[bus_b.imem_addr[15:2]];

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } ent_t;

   ent_t        q[$];
   logic [15:0] m_pc, m_instr_out, m_pc_out;
   bit          m_fault;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic model_reset();
      q.delete();
      m_pc        = 16'h0000;
      m_fault     = 1'b0;
      m_instr_out = 16'h0000;
      m_pc_out    = 16'h0000;
   endtask

   // One rising edge of dut_a, computed from the fetch rules on a queue.
   task automatic model_update();
      bit pop;
      int n_before;
      n_before = q.size();
      pop      = (n_before > 0) && bus_a.out_ready;
      if (pop) void'(q.pop_front());
      if (bus_a.redirect_valid) begin
         q.delete();
         m_pc    = {bus_a.redirect_pc[15:2], 2'b00};
         m_fault = 1'b0;
      end else if (!m_fault && bus_a.fetch_en && (n_before < 2 || pop)) begin
         if (int'(m_pc) < 1024 * 4) begin
            q.push_back('{instr: mem[m_pc[15:2]], pc: m_pc});
            m_pc = m_pc + 16'd4;
         end else begin
            m_fault = 1'b1;
         end
      end
      if (q.size() > 0) begin
         m_instr_out = q[0].instr;
         m_pc_out    = q[0].pc;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   function automatic logic [49:0] obs_a();
      return {bus_a.imem_addr, bus_a.out_valid, bus_a.out_instr, bus_a.out_pc,
              bus_a.fetch_fault};
   endfunction

   function automatic logic [49:0] exp_a();
      logic v;
      v = (q.size() != 0);
      return {m_pc, v, m_instr_out, m_pc_out, m_fault};
   endfunction

   task automatic set_idle();
      bus_a.fetch_en       = 1'b0;
      bus_a.out_ready      = 1'b0;
      bus_a.redirect_valid = 1'b0;
      bus_a.redirect_pc    = 16'h0000;
      bus_b.fetch_en       = 1'b0;
      bus_b.out_ready      = 1'b0;
      bus_b.redirect_valid = 1'b0;
      bus_b.redirect_pc    = 16'h0000;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_idle();
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (obs_a() !== exp_a()) begin
         n_err++;
         $display("FAIL reset_model got %h want %h", obs_a(), exp_a());
      end
      n_vec++;
      if ({bus_a.imem_addr, bus_a.out_valid, bus_a.out_instr, bus_a.out_pc,
           bus_a.fetch_fault} !== 50'd0) begin
         n_err++;
         $display("FAIL reset_values got addr=%h v=%b i=%h pc=%h f=%b want all zero",
                  bus_a.imem_addr, bus_a.out_valid, bus_a.out_instr, bus_a.out_pc,
                  bus_a.fetch_fault);
      end
      n_vec++;
      if (bus_b.imem_addr !== 16'hFFFC || bus_b.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_b got addr=%h v=%b want addr=fffc v=0",
                  bus_b.imem_addr, bus_b.out_valid);
      end
   endtask

   task automatic test_stream();
      logic [15:0] instrs [3];
      instrs[0] = 16'h0688;
      instrs[1] = 16'h1688;
      instrs[2] = 16'h2688;
      do_reset();
      bus_a.fetch_en  = 1'b1;
      bus_a.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_vec++;
         if (obs_a() !== exp_a()) begin
            n_err++;
            $display("FAIL stream_model cyc %0d got %h want %h", i, obs_a(), exp_a());
         end
         if (i < 3) begin
            n_vec++;
            if (bus_a.imem_addr !== 16'(4 * i)) begin
               n_err++;
               $display("FAIL stream_addr cyc %0d got %h want %h", i, bus_a.imem_addr,
                        16'(4 * i));
            end
         end
         if (i >= 1 && i <= 3) begin
            n_vec++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 16'(4 * (i - 1)) ||
                bus_a.out_instr !== instrs[i-1]) begin
               n_err++;
               $display("FAIL stream_out cyc %0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                        i, bus_a.out_valid, bus_a.out_pc, bus_a.out_instr,
                        16'(4 * (i - 1)), instrs[i-1]);
            end
         end
         tick();
      end
   endtask

   task automatic fill_with_backpressure();
      bus_a.fetch_en  = 1'b1;
      bus_a.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (obs_a() !== exp_a()) begin
            n_err++;
            $display("FAIL bp_model cyc %0d got %h want %h", i, obs_a(), exp_a());
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      fill_with_backpressure();
      n_vec++;
      if (bus_a.imem_addr !== 16'h0008 || bus_a.out_pc !== 16'h0000 ||
          bus_a.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_hold got addr=%h pc=%h v=%b want addr=0008 pc=0000 v=1",
                  bus_a.imem_addr, bus_a.out_pc, bus_a.out_valid);
      end
      bus_a.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 16'(4 * k)) begin
            n_err++;
            $display("FAIL bp_drain %0d got v=%b pc=%h want v=1 pc=%h", k,
                     bus_a.out_valid, bus_a.out_pc, 16'(4 * k));
         end
         n_vec++;
         if (obs_a() !== exp_a()) begin
            n_err++;
            $display("FAIL bp_drain_model %0d got %h want %h", k, obs_a(), exp_a());
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      fill_with_backpressure();
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_pc    = 16'h0026;
      tick();
      bus_a.redirect_valid = 1'b0;
      n_vec++;
      if (bus_a.imem_addr !== 16'h0024 || bus_a.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL redir_flush got addr=%h v=%b want addr=0024 v=0",
                  bus_a.imem_addr, bus_a.out_valid);
      end
      bus_a.out_ready = 1'b1;
      tick();
      n_vec++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 16'h0024 ||
          bus_a.out_instr !== mem[9]) begin
         n_err++;
         $display("FAIL redir_first got v=%b pc=%h i=%h want v=1 pc=0024 i=%h",
                  bus_a.out_valid, bus_a.out_pc, bus_a.out_instr, mem[9]);
      end
      n_vec++;
      if (obs_a() !== exp_a()) begin
         n_err++;
         $display("FAIL redir_model got %h want %h", obs_a(), exp_a());
      end
   endtask

   task automatic test_fault();
      do_reset();
      bus_a.fetch_en       = 1'b1;
      bus_a.out_ready      = 1'b1;
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_pc    = 16'h0FFC;
      tick();
      bus_a.redirect_valid = 1'b0;
      tick();
      n_vec++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 16'h0FFC || bus_a.fetch_fault !== 1'b0) begin
         n_err++;
         $display("FAIL fault_last got v=%b pc=%h f=%b want v=1 pc=0ffc f=0",
                  bus_a.out_valid, bus_a.out_pc, bus_a.fetch_fault);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (bus_a.fetch_fault !== 1'b1 || bus_a.out_valid !== 1'b0 ||
             bus_a.imem_addr !== 16'h1000) begin
            n_err++;
            $display("FAIL fault_hold %0d got f=%b v=%b addr=%h want f=1 v=0 addr=1000",
                     i, bus_a.fetch_fault, bus_a.out_valid, bus_a.imem_addr);
         end
      end
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_pc    = 16'h0000;
      tick();
      bus_a.redirect_valid = 1'b0;
      n_vec++;
      if (bus_a.fetch_fault !== 1'b0 || bus_a.imem_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL fault_clear got f=%b addr=%h want f=0 addr=0000",
                  bus_a.fetch_fault, bus_a.imem_addr);
      end
      tick();
      n_vec++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 16'h0000 || obs_a() !== exp_a()) begin
         n_err++;
         $display("FAIL fault_resume got v=%b pc=%h obs=%h want v=1 pc=0000 exp=%h",
                  bus_a.out_valid, bus_a.out_pc, obs_a(), exp_a());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus_b.fetch_en  = 1'b1;
      bus_b.out_ready = 1'b1;
      tick();
      n_vec++;
      if (bus_b.imem_addr !== 16'h0000 || bus_b.out_valid !== 1'b1 ||
          bus_b.out_pc !== 16'hFFFC || bus_b.out_instr !== mem[16383]) begin
         n_err++;
         $display("FAIL wrap_edge got addr=%h v=%b pc=%h i=%h want addr=0000 v=1 pc=fffc i=%h",
                  bus_b.imem_addr, bus_b.out_valid, bus_b.out_pc, bus_b.out_instr, mem[16383]);
      end
      tick();
      n_vec++;
      if (bus_b.imem_addr !== 16'h0004 || bus_b.out_pc !== 16'h0000 ||
          bus_b.out_instr !== mem[0] || bus_b.fetch_fault !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_next got addr=%h pc=%h i=%h f=%b want addr=0004 pc=0000 i=%h f=0",
                  bus_b.imem_addr, bus_b.out_pc, bus_b.out_instr, bus_b.fetch_fault, mem[0]);
      end
      bus_b.fetch_en = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      bus_a.fetch_en  = 1'b1;
      bus_a.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if (bus_a.out_valid !== 1'b0 || bus_a.imem_addr !== 16'h0000 ||
          bus_a.out_pc !== 16'h0000) begin
         n_err++;
         $display("FAIL async_rst got v=%b addr=%h pc=%h want v=0 addr=0000 pc=0000",
                  bus_a.out_valid, bus_a.imem_addr, bus_a.out_pc);
      end
      @(negedge clk);
      model_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (obs_a() !== exp_a()) begin
            n_err++;
            $display("FAIL async_rst_resume %0d got %h want %h", i, obs_a(), exp_a());
         end
      end
   endtask

   task automatic test_random();
      int sel;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bus_a.fetch_en       = ($urandom_range(7) != 0);
         bus_a.out_ready      = ($urandom_range(3) != 0);
         bus_a.redirect_valid = ($urandom_range(15) == 0);
         sel = $urandom_range(2);
         if (sel == 0) bus_a.redirect_pc = 16'($urandom_range(16'h0FFF));
         else if (sel == 1) bus_a.redirect_pc = 16'h0FE0 + 16'($urandom_range(31));
         else bus_a.redirect_pc = 16'($urandom);
         n_vec++;
         if (obs_a() !== exp_a()) begin
            n_err++;
            $display("FAIL random cyc %0d got %h want %h", i, obs_a(), exp_a());
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h0688;
      mem[1] = 16'h1688;
      mem[2] = 16'h2688;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_wrap();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end
endmodule
